// File: rtl/curr_ctrl_debug_capture.sv
// Trace capture into debug RAM port 2: decimated circular buffer with programmable pre-trigger depth.
// Latency: kept sample in cycle N is written in N+1; no backpressure (RAM has no waitrequest, one word/cycle).
module curr_ctrl_debug_capture #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              trig_in,
   input  logic              arm,
   input  logic              abort,
   input  logic [ADDR_W-1:0] pretrig_len,
   input  logic [7:0]        decimate,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_write,
   output logic              ram_chipselect,
   output logic [3:0]        ram_byteenable,
   output logic              ram_clken,
   output logic              busy,
   output logic              triggered,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr
);

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

   state_t            state;
   logic              trig_prev;
   logic              trig_pend;
   logic [7:0]        dec_cnt;
   logic [7:0]        dec_lat;
   logic [ADDR_W-1:0] pre_lat;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [CNT_W-1:0]  post_cnt;

   logic              trig_rise;
   logic              kept;
   logic              capturing;
   logic [CNT_W-1:0]  post_load;

   always_comb begin
      trig_rise = trig_in & ~trig_prev;
      kept      = sample_valid && (dec_cnt == 8'd0);
      capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
      // post count includes the trigger sample itself
      post_load = CNT_W'(DEPTH) - {1'b0, pre_lat};
   end

   assign ram_chipselect = ram_write;
   assign ram_byteenable = 4'hF;
   assign ram_clken      = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         trig_prev     <= 1'b0;
         trig_pend     <= 1'b0;
         dec_cnt       <= 8'd0;
         dec_lat       <= 8'd0;
         pre_lat       <= '0;
         pre_cnt       <= '0;
         wr_ptr        <= '0;
         post_cnt      <= '0;
         ram_address   <= '0;
         ram_writedata <= '0;
         ram_write     <= 1'b0;
         busy          <= 1'b0;
         triggered     <= 1'b0;
         done          <= 1'b0;
         trig_addr     <= '0;
         start_addr    <= '0;
      end else begin
         trig_prev <= trig_in;
         ram_write <= 1'b0;
         if (sample_valid)
            dec_cnt <= (dec_cnt == 8'd0) ? dec_lat : dec_cnt - 8'd1;

         if (abort) begin
            state     <= S_IDLE;
            trig_pend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
         end else begin
            if (capturing && kept) begin
               ram_write     <= 1'b1;
               ram_address   <= wr_ptr;
               ram_writedata <= sample_data;
               wr_ptr        <= wr_ptr + ADDR_W'(1);
            end
            case (state)
               S_IDLE, S_DONE: begin
                  if (arm) begin
                     pre_lat   <= pretrig_len;
                     dec_lat   <= decimate;
                     dec_cnt   <= 8'd0;
                     wr_ptr    <= '0;
                     pre_cnt   <= '0;
                     done      <= 1'b0;
                     triggered <= 1'b0;
                     trig_pend <= 1'b0;
                     busy      <= 1'b1;
                     state     <= (pretrig_len == '0) ? S_ARMED : S_PRE;
                  end
               end
               S_PRE: begin
                  // edges seen here are deliberately dropped
                  if (kept) begin
                     pre_cnt <= pre_cnt + ADDR_W'(1);
                     if ((pre_cnt + ADDR_W'(1)) == pre_lat)
                        state <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (kept && (trig_pend || trig_rise)) begin
                     trig_addr  <= wr_ptr;
                     start_addr <= wr_ptr - pre_lat;
                     triggered  <= 1'b1;
                     trig_pend  <= 1'b0;
                     if (post_load == CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        post_cnt <= post_load - CNT_W'(1);
                        state    <= S_POST;
                     end
                  end else if (trig_rise) begin
                     trig_pend <= 1'b1;
                  end
               end
               S_POST: begin
                  if (kept) begin
                     post_cnt <= post_cnt - CNT_W'(1);
                     if (post_cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
